// File: rtl/eeprom_uwire_pkg.sv
// eeprom_uwire_pkg: shared encodings, frame constants and FSM states for the Microwire master
package eeprom_uwire_pkg;
  typedef enum logic [1:0] {
    MODE_EWEN  = 2'b00,
    MODE_WRITE = 2'b01,
    MODE_READ  = 2'b10,
    MODE_EWDS  = 2'b11
  } mode_e;
  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [6:0] AF_EWEN  = 7'b1100000;
  localparam logic [6:0] AF_EWDS  = 7'b0000000;
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_GAP, S_POLL, S_GAP2} state_e;
  // Left-aligned 18-bit frame; 10-bit commands leave the low 8 bits zero.
  function automatic logic [17:0] build_frame(mode_e m, logic [6:0] a, logic [7:0] d);
    return m == MODE_WRITE ? {1'b1, OP_WRITE, a, d} :
           m == MODE_READ  ? {1'b1, OP_READ, a, 8'h00} :
           m == MODE_EWEN  ? {1'b1, OP_EXT, AF_EWEN, 8'h00} :
                             {1'b1, OP_EXT, AF_EWDS, 8'h00};
  endfunction
endpackage

// File: rtl/eeprom_uwire_master_sk_timer.sv
// uwire_sk_timer: divides clk into sk bit periods (low half then high half) with bit strobes
module uwire_sk_timer #(
  parameter int SK_DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sk_o,
  output logic bit_start_o,
  output logic sample_o
);
  localparam int CW = $clog2(SK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic sk_q, sk_d;
  always_comb begin
    cnt_d = (!en_i || cnt_q == CW'(SK_DIV - 1)) ? '0 : cnt_q + 1'b1;
    sk_d  = en_i && cnt_d >= CW'(SK_DIV / 2);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sk_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sk_q  <= sk_d;
    end
  end
  assign sk_o        = sk_q;
  assign bit_start_o = en_i && cnt_q == '0;
  assign sample_o    = en_i && cnt_q == CW'(SK_DIV - 1);
endmodule

// File: rtl/eeprom_uwire_master.sv
// eeprom_uwire_master: 93C46 x8 Microwire master running one EWEN/WRITE/READ/EWDS per start
module eeprom_uwire_master #(
  parameter int SK_DIV       = 100,
  parameter int CS_GAP       = 100,
  parameter int BUSY_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       rdy,
  output logic [7:0] rdata,
  output logic       rdata_vld,
  output logic       cs,
  output logic       sk,
  output logic       mosi,
  input  logic       miso
);
  import eeprom_uwire_pkg::*;
  localparam int CMAX = CS_GAP > BUSY_TIMEOUT ? CS_GAP : BUSY_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0] bit_q, bit_d, nbits;
  logic [17:0] sr_q, sr_d, frame;
  logic [7:0] rx_q, rx_d, rdata_q, rdata_d;
  logic cs_q, cs_d, mosi_q, mosi_d, vld_q, vld_d;
  logic miso_m_q, miso_s_q, bit_start, sample, is_wr, is_rd;
  uwire_sk_timer #(.SK_DIV(SK_DIV)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q == S_SHIFT),
    .sk_o        (sk),
    .bit_start_o (bit_start),
    .sample_o    (sample)
  );
  assign frame = build_frame(mode_e'(mode), addr, wdata);
  assign is_wr = mode_q == MODE_WRITE;
  assign is_rd = mode_q == MODE_READ;
  assign nbits = (is_wr || is_rd) ? 5'd18 : 5'd10;
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    vld_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d  = mode_e'(mode);
        mosi_d  = frame[17];
        sr_d    = {frame[16:0], 1'b0};
        bit_d   = '0;
        cs_d    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bit_start) bit_d = bit_q + 1'b1;
        // Next bit is loaded at the end of the high phase so it changes as sk goes low.
        if (sample) begin
          mosi_d = sr_q[17];
          sr_d   = {sr_q[16:0], 1'b0};
          if (is_rd && bit_q > 5'd10) rx_d = {rx_q[6:0], miso_s_q};
          if (bit_q == nbits) begin
            cs_d    = 1'b0;
            cnt_d   = '0;
            rdata_d = is_rd ? rx_d : rdata_q;
            vld_d   = is_rd;
            state_d = S_GAP;
          end
        end
      end
      S_GAP, S_GAP2: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CS_GAP - 1)) begin
          cnt_d   = '0;
          cs_d    = state_q == S_GAP && is_wr;
          state_d = (state_q == S_GAP && is_wr) ? S_POLL : S_IDLE;
        end
      end
      S_POLL: begin
        cnt_d = cnt_q + 1'b1;
        if (miso_s_q || cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          cnt_d   = '0;
          cs_d    = 1'b0;
          state_d = S_GAP2;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_EWEN;
      cnt_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      cs_q     <= 1'b0;
      mosi_q   <= 1'b0;
      vld_q    <= 1'b0;
      miso_m_q <= 1'b0;
      miso_s_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      vld_q    <= vld_d;
      miso_m_q <= miso;
      miso_s_q <= miso_m_q;
    end
  end
  assign rdy       = state_q == S_IDLE;
  assign rdata     = rdata_q;
  assign rdata_vld = vld_q;
  assign cs        = cs_q;
  assign mosi      = mosi_q;
endmodule

// File: tb/tb_eeprom_uwire_master.sv
// tb_eeprom_uwire_master: directed commands with a serial-bus monitor scoreboarding frames and read data
module tb_eeprom_uwire_master;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] mode = 0;
  logic [6:0] addr = 0;
  logic [7:0] wdata = 0, rdata, rd_pat = 0;
  logic rdy, rdata_vld, cs, sk, mosi, miso;
  logic miso_lvl = 0, miso_rd = 0, drv_read = 0;
  int vec_cnt = 0, err_cnt = 0, vld_hi = 0, sk_err = 0;
  typedef struct {int n; logic [17:0] bits;} frame_t;
  frame_t fq[$];
  logic [7:0] rq[$];
  assign miso = drv_read ? miso_rd : miso_lvl;
  always #5 clk = ~clk;
  eeprom_uwire_master #(.SK_DIV(100), .CS_GAP(100), .BUSY_TIMEOUT(4000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .addr(addr), .wdata(wdata),
    .rdy(rdy), .rdata(rdata), .rdata_vld(rdata_vld), .cs(cs), .sk(sk), .mosi(mosi), .miso(miso)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic exp_frame(input int n, input logic [17:0] b);
    frame_t f;
    f.n = n;
    f.bits = b;
    fq.push_back(f);
  endtask
  // Monitor: captures mosi on each sk rise, closes a frame on cs fall, plays EEPROM read data.
  initial begin
    int nb;
    logic [17:0] bits;
    logic cs_p, sk_p;
    frame_t f;
    nb = 0; bits = '0; cs_p = 0; sk_p = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nb = 0; bits = '0; cs_p = 0; sk_p = 0;
      end else begin
        if (!cs && sk) sk_err++;
        if (sk && !sk_p) begin
          nb++;
          bits = {bits[16:0], mosi};
          if (nb >= 11 && nb <= 18) miso_rd = rd_pat[18-nb];
        end
        if (cs_p && !cs) begin
          chk("frame_queued", fq.size() != 0, 1);
          if (fq.size() != 0) begin
            f = fq.pop_front();
            chk("frame_len", nb, f.n);
            chk("frame_bits", bits, f.bits);
          end
          nb = 0; bits = '0;
        end
        if (rdata_vld) begin
          vld_hi++;
          chk("vld_at_cs_fall", cs_p && !cs, 1);
          chk("read_queued", rq.size() != 0, 1);
          if (rq.size() != 0) chk("rdata", rdata, rq.pop_front());
        end
        cs_p = cs; sk_p = sk;
      end
    end
  end
  task automatic run_cmd(input logic [1:0] m, input logic [6:0] a, input logic [7:0] d,
                         input int exp_busy, input int exp_vld, input int raise_at, input bit disturb);
    int cnt, v0;
    v0 = vld_hi;
    mode = m; addr = a; wdata = d; start = 1;
    @(negedge clk);
    start = 0;
    cnt = 0;
    while (!rdy && cnt < 20000) begin
      cnt++;
      if (raise_at == cnt) miso_lvl = 1;
      if (disturb && cnt == 500) begin start = 1; mode = 2'b01; addr = 7'h7F; wdata = 8'hFF; end
      if (disturb && cnt == 501) start = 0;
      if (disturb && cnt == 900) begin mode = 2'b11; addr = 7'h00; end
      @(negedge clk);
    end
    miso_lvl = 0;
    chk("busy_cycles", cnt, exp_busy);
    @(negedge clk);
    chk("vld_cycles", vld_hi - v0, exp_vld);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_cs", cs, 0);
    chk("rst_sk", sk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rdy", rdy, 1);
    chk("rst_vld", rdata_vld, 0);
    chk("rst_rdata", rdata, 0);
    // WRITE, EEPROM reports ready 3000 cycles into polling
    exp_frame(18, 18'b1_01_0010110_01010101);
    exp_frame(0, 18'h0);
    run_cmd(2'b01, 7'h16, 8'h55, 5003, 0, 4901, 0);
    // READ with miso held high
    exp_frame(18, 18'b1_10_0010110_00000000);
    rq.push_back(8'hFF);
    miso_lvl = 1;
    run_cmd(2'b10, 7'h16, 8'h00, 1900, 1, 0, 0);
    // READ with 0xA5 played on input clocks
    drv_read = 1; rd_pat = 8'hA5;
    exp_frame(18, 18'b1_10_0010110_00000000);
    rq.push_back(8'hA5);
    run_cmd(2'b10, 7'h16, 8'h00, 1900, 1, 0, 0);
    drv_read = 0;
    exp_frame(10, 18'b10_0110_0000);
    run_cmd(2'b00, 7'h16, 8'h00, 1100, 0, 0, 0);
    exp_frame(10, 18'b10_0000_0000);
    run_cmd(2'b11, 7'h16, 8'h00, 1100, 0, 0, 0);
    // READ disturbed by a start pulse and input changes mid-frame
    drv_read = 1; rd_pat = 8'h3C;
    exp_frame(18, 18'b1_10_0101010_00000000);
    rq.push_back(8'h3C);
    run_cmd(2'b10, 7'h2A, 8'h00, 1900, 1, 0, 1);
    drv_read = 0;
    // Reset in the middle of a WRITE frame
    mode = 2'b01; addr = 7'h16; wdata = 8'h55; start = 1;
    @(negedge clk);
    start = 0;
    repeat (760) @(negedge clk);
    chk("pre_rst_cs", cs, 1);
    chk("pre_rst_sk", sk, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_cs", cs, 0);
    chk("mid_rst_sk", sk, 0);
    chk("mid_rst_rdy", rdy, 1);
    chk("mid_rst_rdata", rdata, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    exp_frame(10, 18'b10_0110_0000);
    run_cmd(2'b00, 7'h00, 8'h00, 1100, 0, 0, 0);
    // WRITE with miso stuck low: polling times out
    exp_frame(18, 18'b1_01_1111111_10100011);
    exp_frame(0, 18'h0);
    run_cmd(2'b01, 7'h7F, 8'hA3, 6000, 0, 0, 0);
    chk("sk_low_while_cs_low", sk_err, 0);
    chk("frames_pending", fq.size(), 0);
    chk("reads_pending", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
